// File: rtl/pulsar_pkg.sv
// Shared definitions for the PWM fade sequencer.
//   fade_state_e : sequencer FSM state (idle / sweeping the channel bank)
//   chan_bits()  : width of a channel index for a given channel count
package pulsar_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StSweep
  } fade_state_e;

  // Channel-index width; a single-channel build still needs a 1-bit index.
  function automatic int unsigned chan_bits(input int unsigned num_pwm);
    return (num_pwm > 1) ? $clog2(num_pwm) : 1;
  endfunction

endpackage

// File: rtl/pwm_fade_sequencer_if.sv
// Command and threshold-write bus of the PWM fade sequencer.
//   cmd_valid/cmd_ready : fade command handshake (issuer -> sequencer)
//   cmd_chan/target/step: command payload
//   wr_valid/chan/data  : threshold-bank write strobe and payload (sequencer -> bank)
// Modports: master = command issuer / bank side, slave = sequencer.
interface pwm_fade_sequencer_if import pulsar_pkg::*; #(
  parameter int unsigned PWM_WIDTH = 16,
  parameter int unsigned NUM_PWM   = 12
) ();

  localparam int unsigned CHAN_BITS = chan_bits(NUM_PWM);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [CHAN_BITS-1:0] cmd_chan;
  logic [PWM_WIDTH-1:0] cmd_target;
  logic [PWM_WIDTH-1:0] cmd_step;

  logic                 wr_valid;
  logic [CHAN_BITS-1:0] wr_chan;
  logic [PWM_WIDTH-1:0] wr_data;

  modport master (
    output cmd_valid,
    input  cmd_ready,
    output cmd_chan,
    output cmd_target,
    output cmd_step,
    input  wr_valid,
    input  wr_chan,
    input  wr_data
  );

  modport slave (
    input  cmd_valid,
    output cmd_ready,
    input  cmd_chan,
    input  cmd_target,
    input  cmd_step,
    output wr_valid,
    output wr_chan,
    output wr_data
  );

endinterface

// File: rtl/fade_step.sv
// Combinational single-step fade arithmetic.
//   cur_i  : present threshold
//   tgt_i  : final threshold
//   step_i : per-period magnitude, 0 = jump straight to target
//   nxt_o  : next threshold, clamped at target, never wrapping
module fade_step #(
  parameter int unsigned PWM_WIDTH = 16
) (
  input  logic [PWM_WIDTH-1:0] cur_i,
  input  logic [PWM_WIDTH-1:0] tgt_i,
  input  logic [PWM_WIDTH-1:0] step_i,
  output logic [PWM_WIDTH-1:0] nxt_o
);

  // One extra bit catches carry on the way up and borrow on the way down.
  logic [PWM_WIDTH:0] sum;
  logic [PWM_WIDTH:0] diff;
  logic [PWM_WIDTH:0] tgt_ext;

  assign tgt_ext = {1'b0, tgt_i};
  assign sum     = {1'b0, cur_i} + {1'b0, step_i};
  assign diff    = {1'b0, cur_i} - {1'b0, step_i};

  always_comb begin
    nxt_o = cur_i;
    if (step_i == '0) begin
      nxt_o = tgt_i;
    end else if (cur_i < tgt_i) begin
      nxt_o = (sum > tgt_ext) ? tgt_i : sum[PWM_WIDTH-1:0];
    end else if (cur_i > tgt_i) begin
      // diff[PWM_WIDTH] set means the subtraction went below zero.
      nxt_o = (diff[PWM_WIDTH] || (diff < tgt_ext)) ? tgt_i : diff[PWM_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// PWM fade sequencer: holds per-channel cur/target/step registers and, on each
// period tick, sweeps all channels one per cycle, moving each cur one step
// towards its target and emitting a registered threshold write when it changes.
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   tick_i    : one-cycle pulse per PWM period, starts a sweep
//   busy_o    : sweep in progress
//   overrun_o : sticky, a tick arrived during a sweep
//   bus       : command handshake in, threshold writes out (slave side)
module pwm_fade_sequencer import pulsar_pkg::*; #(
  parameter int unsigned PWM_WIDTH = 16,
  parameter int unsigned NUM_PWM   = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tick_i,
  output logic                        busy_o,
  output logic                        overrun_o,
  pwm_fade_sequencer_if.slave         bus
);

  localparam int unsigned CHAN_BITS = chan_bits(NUM_PWM);
  localparam logic [CHAN_BITS-1:0] LastIdx = CHAN_BITS'(NUM_PWM - 1);

  fade_state_e          state_q, state_d;
  logic [CHAN_BITS-1:0] idx_q, idx_d;
  logic [PWM_WIDTH-1:0] cur_q  [NUM_PWM];
  logic [PWM_WIDTH-1:0] cur_d  [NUM_PWM];
  logic [PWM_WIDTH-1:0] tgt_q  [NUM_PWM];
  logic [PWM_WIDTH-1:0] tgt_d  [NUM_PWM];
  logic [PWM_WIDTH-1:0] step_q [NUM_PWM];
  logic [PWM_WIDTH-1:0] step_d [NUM_PWM];
  logic                 wr_valid_q, wr_valid_d;
  logic [CHAN_BITS-1:0] wr_chan_q, wr_chan_d;
  logic [PWM_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                 overrun_q, overrun_d;

  logic                 cmd_ready;
  logic                 cmd_chan_ok;
  logic [PWM_WIDTH-1:0] nxt;

  // No command may be taken while reset is held.
  assign cmd_ready   = (state_q == StIdle) && !rst;
  assign cmd_chan_ok = int'(bus.cmd_chan) < int'(NUM_PWM);

  fade_step #(
    .PWM_WIDTH (PWM_WIDTH)
  ) u_fade_step (
    .cur_i  (cur_q[idx_q]),
    .tgt_i  (tgt_q[idx_q]),
    .step_i (step_q[idx_q]),
    .nxt_o  (nxt)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cur_d      = cur_q;
    tgt_d      = tgt_q;
    step_d     = step_q;
    wr_valid_d = 1'b0;
    wr_chan_d  = wr_chan_q;
    wr_data_d  = wr_data_q;
    overrun_d  = overrun_q;

    unique case (state_q)
      StIdle: begin
        // Out-of-range channels are handshaken but dropped.
        if (bus.cmd_valid && cmd_ready && cmd_chan_ok) begin
          tgt_d[bus.cmd_chan]  = bus.cmd_target;
          step_d[bus.cmd_chan] = bus.cmd_step;
        end
        if (tick_i) begin
          state_d = StSweep;
          idx_d   = '0;
        end
      end
      StSweep: begin
        if (tick_i) begin
          overrun_d = 1'b1;
        end
        if (nxt != cur_q[idx_q]) begin
          cur_d[idx_q] = nxt;
          wr_valid_d   = 1'b1;
          wr_chan_d    = idx_q;
          wr_data_d    = nxt;
        end
        if (idx_q == LastIdx) begin
          state_d = StIdle;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + CHAN_BITS'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cur_q      <= '{default: '0};
      tgt_q      <= '{default: '0};
      step_q     <= '{default: '0};
      wr_valid_q <= 1'b0;
      wr_chan_q  <= '0;
      wr_data_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cur_q      <= cur_d;
      tgt_q      <= tgt_d;
      step_q     <= step_d;
      wr_valid_q <= wr_valid_d;
      wr_chan_q  <= wr_chan_d;
      wr_data_q  <= wr_data_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.wr_valid  = wr_valid_q;
  assign bus.wr_chan   = wr_chan_q;
  assign bus.wr_data   = wr_data_q;
  assign busy_o        = (state_q == StSweep);
  assign overrun_o     = overrun_q;

endmodule

// File: doc/pwm_fade_sequencer.md
PWM_FADE_SEQUENCER -- requirements
Module: pwm_fade_sequencer

Interface
REQ-001 Parameter PWM_WIDTH, default 16, bit width of every threshold, target and step value.
REQ-002 Parameter NUM_PWM, default 12, number of PWM channels sequenced.
REQ-003 Derived constant CHAN_BITS = $clog2(NUM_PWM) SHALL size every channel index.
REQ-004 clk  input  1  Rising-edge clock for all state.
REQ-005 rst  input  1  Reset, asynchronous, active-high.
REQ-006 tick  input  1  Single-cycle pulse, once per PWM period; starts one sweep.
REQ-007 cmd_valid  input  1  Fade command present.
REQ-008 cmd_ready  output  1  Command accepted when cmd_valid and cmd_ready are both high at a clk edge.
REQ-009 cmd_chan  input  CHAN_BITS  Target channel of the command.
REQ-010 cmd_target  input  PWM_WIDTH  Final threshold for the channel.
REQ-011 cmd_step  input  PWM_WIDTH  Per-period increment magnitude; 0 means jump to target.
REQ-012 wr_valid  output  1  Threshold-bank write strobe, one cycle per write.
REQ-013 wr_chan  output  CHAN_BITS  Channel being written.
REQ-014 wr_data  output  PWM_WIDTH  New threshold value.
REQ-015 busy  output  1  High while a sweep is in progress.
REQ-016 overrun  output  1  Sticky flag: tick arrived while busy.

Function
REQ-017 Per channel the block SHALL hold cur, target and step registers of PWM_WIDTH bits each.
REQ-018 FSM states SHALL be IDLE and SWEEP; busy = (state == SWEEP).
REQ-019 cmd_ready SHALL equal (state == IDLE).
REQ-020 On an accepted command with cmd_chan < NUM_PWM, target[cmd_chan] and step[cmd_chan] SHALL be loaded; cur is unchanged.
REQ-021 An accepted command with cmd_chan >= NUM_PWM SHALL be consumed and discarded with no state change.
REQ-022 In IDLE, tick SHALL move the FSM to SWEEP with sweep index = 0 on the next cycle.
REQ-023 Simultaneous accepted command and tick in IDLE: the command SHALL be applied and the following sweep SHALL use the new values.
REQ-024 In SWEEP, exactly one channel (the sweep index) SHALL be evaluated per cycle, and the index SHALL increment by 1.
REQ-025 After evaluating index NUM_PWM-1, the FSM SHALL return to IDLE; a sweep lasts exactly NUM_PWM cycles.
REQ-026 Next value: if step == 0, the result is target; if cur < target, min(cur+step, target); if cur > target, max(cur-step, target); else cur.
REQ-027 The next-value calculation SHALL use PWM_WIDTH+1-bit intermediates; the result SHALL never overshoot target or wrap.
REQ-028 If next != cur, cur SHALL be updated, and wr_valid/wr_chan/wr_data SHALL present it registered, one cycle after the evaluation cycle.
REQ-029 If next == cur, no write SHALL be issued for that channel.
REQ-030 wr_valid SHALL be low in every cycle not covered by REQ-028.
REQ-031 A tick received while in SWEEP SHALL be ignored for sequencing and SHALL set overrun, which stays set until reset.

Reset
REQ-032 Asserting rst SHALL immediately clear all cur, target and step registers, the sweep index, wr_valid, wr_chan, wr_data and overrun, and force the FSM to IDLE.
REQ-033 Reset asserted mid-sweep SHALL abort the sweep, and no wr_valid SHALL appear after reset asserts.
REQ-034 No command SHALL be accepted while rst is high.

Structure
REQ-035 The FSM state enum and the CHAN_BITS derivation SHALL live in the shared package pulsar_pkg.
REQ-036 The next-value arithmetic of REQ-026/027 SHALL be a combinational sub-module, fade_step.

Verification
REQ-037 Target 0x0100 with step 0x0040 on ch 3 from cur 0, then 5 ticks: writes to ch 3 of 0x0040, 0x0080, 0x00C0, 0x0100; no write on the 5th tick.
REQ-038 cur 0x0100, target 0x0000, step 0x0300 on ch 0, then 1 tick: a single write of 0x0000, with no wrap.
REQ-039 Step 0 with target 0xFFFF on ch 11, then tick: one write of 0xFFFF 1 cycle after ch 11 is evaluated; busy is high for exactly 12 cycles.
REQ-040 cmd_chan = 13, then tick: the command is accepted and no writes occur.
REQ-041 A second tick 5 cycles into a sweep: overrun = 1, the sweep still completes with 12 cycles, and no extra sweep runs.
REQ-042 rst asserted at sweep index 6: all outputs are 0 and the FSM is in IDLE; the next tick after release re-ramps from cur = 0.
